// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rtl/nibble_serial_add_ctrl_pkg.sv - shared FSM encodings and nibble constants
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_BITS = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef logic [NIB_BITS-1:0] nibble_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_add4_slice.sv
// rtl/nibble_serial_add_ctrl_add4_slice.sv - combinational 4-bit ripple-carry adder slice
module add4_slice
  import nibble_serial_add_ctrl_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  output nibble_t s,
  output logic    co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < NIB_BITS; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - nibble-serial WIDTH-bit adder sequencer with valid/ready handshakes
// Optional SUBTRACT_EN adds a `sub` input selecting a - b.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIB_BITS;
  localparam int CW  = $clog2(NIB);

  if ((WIDTH % NIB_BITS) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  nibble_t          slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SUBTRACT_EN
  // Two's-complement subtract: a + ~b + 1, so cout=1 means no borrow.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  add4_slice u_slice (
    .a  (a_sr[NIB_BITS-1:0]),
    .b  (b_sr[NIB_BITS-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Result nibbles enter at the top so the LSB nibble lands at bit 0 after NIB steps.
          sum   <= {slice_s, sum[WIDTH-1:NIB_BITS]};
          a_sr  <= a_sr >> NIB_BITS;
          b_sr  <= b_sr >> NIB_BITS;
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIB - 1)) begin
            cout  <= slice_co;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - scoreboard bench for nibble_serial_add_ctrl (WIDTH 16, 8, 32)
module tb_nibble_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SUBTRACT_EN
  logic         sub;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic [W:0] exp_q[$];
  logic ready_rand = 1'b0;
  logic ready_val  = 1'b1;
  logic main_done  = 1'b0;

  nibble_serial_add_ctrl #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_val;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard for the 16-bit instance
  logic         prev_ov = 1'b0, prev_stall = 1'b0, prev_hs = 1'b0, prev_cout = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic [W:0]   mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0; prev_stall = 1'b0; prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("ready_after_hs", in_ready, 1);
        chk("valid_after_hs", out_valid, 0);
      end
      if (out_valid && !prev_ov) chk("latency", cyc - acc_cyc, NIB);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_sum", sum, prev_sum);
        chk("hold_cout", cout, prev_cout);
      end
      if (out_valid) chk("in_ready_in_done", in_ready, 0);
      prev_hs    = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      if (prev_hs) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: actual sum %0h with no pending expectation", sum);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sum", sum, mon_e[W-1:0]);
          chk("cout", cout, mon_e[W]);
        end
      end
      prev_ov = out_valid; prev_sum = sum; prev_cout = cout;
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [W:0] texp);
    int guard = 0;
    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: actual in_ready 0 required 1");
      return;
    end
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    exp_q.push_back(texp);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
`ifdef SUBTRACT_EN
    sub = 1'b0;
`endif
    issue(ta, tb_, tc, {1'b0, ta} + {1'b0, tb_} + (W+1)'(tc));
  endtask

`ifdef SUBTRACT_EN
  task automatic send_sub(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    logic [W-1:0] diff;
    diff = ta - tb_;
    sub = 1'b1;
    issue(ta, tb_, 1'($urandom_range(0, 1)), {ta >= tb_, diff});
  endtask
`endif

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 500) begin @(posedge clk); #1; guard++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: actual %0d pending results required 0", exp_q.size());
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SUBTRACT_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h1234, 16'h4321, 1'b0);
    wait_idle();
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1);
    wait_idle();

    // Backpressure with in_valid toggling during DONE
    ready_val = 1'b0;
    send(16'hA5A5, 16'h5A5B, 1'b0);
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    chk("bp_reached_done", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a = W'($urandom);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ready_val = 1'b1;
    wait_idle();

    // Reset after the second nibble step
    send(16'hBEEF, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0);
    wait_idle();

`ifdef SUBTRACT_EN
    send_sub(16'h0005, 16'h0007);
    send_sub(16'h0007, 16'h0005);
    wait_idle();
`endif

    ready_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
`ifdef SUBTRACT_EN
      if ($urandom_range(0, 1) == 1) send_sub(W'($urandom), W'($urandom));
      else send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
`else
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
`endif
    end
    wait_idle();
    ready_rand = 1'b0;
    main_done = 1'b1;

    guard = 0;
    while (!(g_sweep[0].sweep_fin && g_sweep[1].sweep_fin) && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    if (!(g_sweep[0].sweep_fin && g_sweep[1].sweep_fin)) begin
      n_checks++; n_fail++;
      $display("FAIL sweep_timeout: actual unfinished required finished");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Random sweeps at WIDTH=8 and WIDTH=32 with random out_ready stalls
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int GW = (g == 0) ? 8 : 32;
    logic          sv = 1'b0, scin = 1'b0, sor = 1'b1;
    logic          sir, sov, scout;
    logic [GW-1:0] sa = '0, sb = '0, ssum;
    logic [GW:0]   sq[$];
    logic [GW:0]   se;
    logic          sweep_fin = 1'b0;
`ifdef SUBTRACT_EN
    logic          ssub = 1'b0;
`endif

    nibble_serial_add_ctrl #(.WIDTH(GW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sv),
      .in_ready  (sir),
      .a         (sa),
      .b         (sb),
      .cin       (scin),
`ifdef SUBTRACT_EN
      .sub       (ssub),
`endif
      .out_valid (sov),
      .out_ready (sor),
      .sum       (ssum),
      .cout      (scout)
    );

    always @(posedge clk) begin
      #2;
      sor = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (rst_n && sov && sor) begin
        if (sq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sweep%0d_unexpected: actual sum %0h with no pending expectation", GW, ssum);
        end else begin
          se = sq.pop_front();
          chk($sformatf("sweep%0d_sum", GW), 64'(ssum), 64'(se[GW-1:0]));
          chk($sformatf("sweep%0d_cout", GW), scout, se[GW]);
        end
      end
    end

    initial begin
      int guard;
      wait (main_done);
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
        guard = 0;
        while (!sir && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!sir) begin
          n_checks++; n_fail++;
          $display("FAIL sweep%0d_accept_timeout: actual in_ready 0 required 1", GW);
          break;
        end
        sa = GW'($urandom);
        sb = GW'($urandom);
        scin = 1'($urandom_range(0, 1));
        sq.push_back({1'b0, sa} + {1'b0, sb} + (GW+1)'(scin));
        sv = 1'b1;
        @(posedge clk); #1;
        sv = 1'b0;
      end
      guard = 0;
      while (sq.size() != 0 && guard < 500) begin @(posedge clk); #1; guard++; end
      if (sq.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL sweep%0d_drain: actual %0d pending required 0", GW, sq.size());
      end
      sweep_fin = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
